// File: rtl/risc_v_mike_mem_arb.sv
// risc_v_mike_mem_arb: fetch / load-store arbiter in front of one shared
// single-ported, synchronous-read memory.
// The macro RISC_V_MIKE_MEM_ARB_FIX_PRIO_EN selects fixed priority (data port
// always wins a conflict). When it is undefined, conflicts are resolved round-robin.
module risc_v_mike_mem_arb #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  // instruction-fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  // load/store port
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  // memory macro port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  // Conflict winner: high when the data port takes a cycle both ports request
  logic dm_wins;

`ifdef RISC_V_MIKE_MEM_ARB_FIX_PRIO_EN
  // Fixed priority: data always wins, fetch may starve
  always_comb begin
    dm_wins = 1'b1;
  end
`else
  owner_t last_gnt;
  owner_t last_gnt_nxt;

  // Remember which port was granted last; reset value hands the first conflict to data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= FETCH;
    end else begin
      last_gnt <= last_gnt_nxt;
    end
  end

  // Round-robin: the port not granted most recently wins; track every grant
  always_comb begin
    dm_wins      = (last_gnt == FETCH);
    last_gnt_nxt = last_gnt;
    if (dm_gnt) begin
      last_gnt_nxt = DATA;
    end else if (if_gnt) begin
      last_gnt_nxt = FETCH;
    end
  end
`endif

  // Same-cycle grant and memory-port mux; everything idles to zero in reset
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (!rst) begin
      if (dm_req && (!if_req || dm_wins)) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
    if (dm_gnt) begin
      mem_req   = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_be    = dm_be;
    end else if (if_gnt) begin
      mem_req   = 1'b1;
      mem_addr  = if_addr;
      mem_be    = {BE_W{1'b1}};
    end
  end

  // Response tracking: one {valid, owner} slot per cycle of memory latency
  logic [MEM_LAT-1:0] pipe_vld;
  logic [MEM_LAT-1:0] pipe_own;
  logic               rd_issue;
  logic               rd_owner;

  // A granted read enters the pipeline tagged with the granted port
  always_comb begin
    rd_issue = mem_req & ~mem_we;
    rd_owner = dm_gnt;
  end

  // Shift slots toward the tail; reset drops everything in flight at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      pipe_vld[0] <= rd_issue;
      pipe_own[0] <= rd_owner;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  // Tail slot steers the response; read data is shared and only qualified by rvalid
  always_comb begin
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    if (!rst) begin
      if_rvalid = pipe_vld[MEM_LAT-1] & (pipe_own[MEM_LAT-1] == FETCH);
      dm_rvalid = pipe_vld[MEM_LAT-1] & (pipe_own[MEM_LAT-1] == DATA);
      if_rdata  = mem_rdata;
      dm_rdata  = mem_rdata;
    end
  end

endmodule
